// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: synchronizes the phase pins and emits step/dir pulses and a wrapping N-bit position.
// Optional index input z and load-to-INDEX_VAL logic are compiled in when QDEC_INDEX_EN is defined.
module quad_step_decoder #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int INDEX_VAL   = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a,
  input  logic         b,
`ifdef QDEC_INDEX_EN
  input  logic         z,
`endif
  input  logic         en,
  input  logic         clr,
  output logic [N-1:0] q,
  output logic         step,
  output logic         dir,
  output logic         err,
  output logic         err_flag,
  output logic         ready
);

  typedef enum logic {INIT, RUN} state_t;

  localparam int CW = $clog2(SYNC_STAGES + 1);

  state_t          state_reg, state_next;
  logic [CW-1:0]   init_cnt_reg;
  logic            init_done;

  logic [SYNC_STAGES-1:0] sync_a_reg, sync_b_reg;
  logic [1:0]      s, s_ahead, prev_reg;
  logic [1:0]      pos_s, pos_prev, delta;

  logic [N-1:0]    q_reg, q_next;
  logic            step_reg, step_next;
  logic            dir_reg, dir_next;
  logic            err_reg, err_next;
  logic            err_flag_reg, err_flag_next;
  logic            index_hit;

  // Gray code {a,b} to position: 00->0, 01->1, 11->2, 10->3
  function automatic logic [1:0] gray_pos(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a_reg <= '0;
      sync_b_reg <= '0;
    end else begin
      sync_a_reg <= {sync_a_reg[SYNC_STAGES-2:0], a};
      sync_b_reg <= {sync_b_reg[SYNC_STAGES-2:0], b};
    end
  end

  assign s       = {sync_a_reg[SYNC_STAGES-1], sync_b_reg[SYNC_STAGES-1]};
  assign s_ahead = {sync_a_reg[SYNC_STAGES-2], sync_b_reg[SYNC_STAGES-2]};

`ifdef QDEC_INDEX_EN
  localparam logic [N-1:0] INDEX_Q = INDEX_VAL[N-1:0];

  logic [SYNC_STAGES-1:0] sync_z_reg;
  logic                   z_prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_z_reg <= '0;
      z_prev_reg <= 1'b0;
    end else begin
      sync_z_reg <= {sync_z_reg[SYNC_STAGES-2:0], z};
      z_prev_reg <= sync_z_reg[SYNC_STAGES-1];
    end
  end

  assign index_hit = sync_z_reg[SYNC_STAGES-1] & ~z_prev_reg;
`else
  assign index_hit = 1'b0;
`endif

  assign init_done = (state_reg == INIT) && (init_cnt_reg == CW'(SYNC_STAGES - 1));

  // State register plus priming counter and previous-phase tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= INIT;
      init_cnt_reg <= '0;
      prev_reg     <= 2'b00;
    end else begin
      state_reg <= state_next;
      if (state_reg == INIT)
        init_cnt_reg <= init_cnt_reg + 1'b1;
      // On the priming edge, capture the value s is about to take so the
      // power-up pin level is treated as the starting phase, not a transition.
      prev_reg <= init_done ? s_ahead : s;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (init_done)
      state_next = RUN;
  end

  assign pos_s    = gray_pos(s);
  assign pos_prev = gray_pos(prev_reg);
  assign delta    = pos_s - pos_prev;

  always_comb begin
    q_next        = q_reg;
    step_next     = 1'b0;
    dir_next      = dir_reg;
    err_next      = 1'b0;
    err_flag_next = err_flag_reg;
    if (state_reg == RUN) begin
      case (delta)
        2'd1: if (en) begin
          step_next = 1'b1;
          dir_next  = 1'b0;
          q_next    = q_reg + 1'b1;
        end
        2'd3: if (en) begin
          step_next = 1'b1;
          dir_next  = 1'b1;
          q_next    = q_reg - 1'b1;
        end
        2'd2: begin
          err_next      = 1'b1;
          err_flag_next = 1'b1;
        end
        default: ;
      endcase
`ifdef QDEC_INDEX_EN
      if (index_hit)
        q_next = INDEX_Q;
`endif
    end
    if (clr) begin
      q_next        = '0;
      err_flag_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg        <= '0;
      step_reg     <= 1'b0;
      dir_reg      <= 1'b0;
      err_reg      <= 1'b0;
      err_flag_reg <= 1'b0;
    end else begin
      q_reg        <= q_next;
      step_reg     <= step_next;
      dir_reg      <= dir_next;
      err_reg      <= err_next;
      err_flag_reg <= err_flag_next;
    end
  end

  assign q        = q_reg;
  assign step     = step_reg;
  assign dir      = dir_reg;
  assign err      = err_reg;
  assign err_flag = err_flag_reg;
  assign ready    = (state_reg == RUN);

  logic unused_index;
  assign unused_index = index_hit;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed self-checking bench for quad_step_decoder (N=4, SYNC_STAGES=2).
// Index tests run only when QDEC_INDEX_EN is defined.
module tb_quad_step_decoder;

  logic       clk = 1'b0;
  logic       rst_n, a, b, en, clr;
  logic [3:0] q;
  logic       step, dir, err, err_flag, ready;
`ifdef QDEC_INDEX_EN
  logic       z = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  quad_step_decoder #(.N(4), .SYNC_STAGES(2), .INDEX_VAL(4'hA)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
`ifdef QDEC_INDEX_EN
    .z(z),
`endif
    .en(en), .clr(clr), .q(q), .step(step), .dir(dir),
    .err(err), .err_flag(err_flag), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one phase value and observe the 4 following cycles:
  // early = any pulse before the expected edge, st/dr/er at the edge, late after it.
  task automatic do_phase(input logic [1:0] v, output logic early, output logic st,
                          output logic dr, output logic er, output logic late);
    {a, b} = v;
    tick();
    tick();
    early = step | err;
    tick();
    st = step;
    dr = dir;
    er = err;
    tick();
    late = step | err;
  endtask

  task automatic test_reset();
    logic e0, st, dr, er, lt;
    rst_n = 1'b0; a = 1'b1; b = 1'b1; en = 1'b1; clr = 1'b0;
    repeat (3) tick();
    checks++; if (q !== 4'h0 || ready !== 1'b0 || step !== 1'b0 || err !== 1'b0 || err_flag !== 1'b0 || dir !== 1'b0) begin
      errors++; $display("FAIL reset_state: q=%0h ready=%0b step=%0b err=%0b flag=%0b dir=%0b required 0", q, ready, step, err, err_flag, dir);
    end
    rst_n = 1'b1;
    tick();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ready_edge1: got %0b required 0", ready); end
    tick();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ready_edge2: got %0b required 1", ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (step !== 1'b0 || err !== 1'b0 || q !== 4'h0) begin
        errors++; $display("FAIL powerup_quiet: step=%0b err=%0b q=%0h required 0 0 0", step, err, q);
      end
    end
    do_phase(2'b01, e0, st, dr, er, lt);
    checks++; if (e0 !== 1'b0 || st !== 1'b1 || dr !== 1'b1 || er !== 1'b0 || lt !== 1'b0) begin
      errors++; $display("FAIL first_down: early=%0b step=%0b dir=%0b err=%0b late=%0b required 0 1 1 0 0", e0, st, dr, er, lt);
    end
    checks++; if (q !== 4'hF) begin errors++; $display("FAIL first_down_q: got %0h required f", q); end
  endtask

  task automatic test_up();
    logic e0, st, dr, er, lt;
    logic [1:0] seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [3:0] exp_q;
    int nsteps;
    do_phase(2'b00, e0, st, dr, er, lt);
    checks++; if (q !== 4'hE) begin errors++; $display("FAIL pre_up_q: got %0h required e", q); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL clr_q: got %0h required 0", q); end
    exp_q = 4'h0;
    nsteps = 0;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) begin
        do_phase(seq[k], e0, st, dr, er, lt);
        exp_q = exp_q + 4'h1;
        if (st === 1'b1) nsteps++;
        checks++; if (e0 !== 1'b0 || st !== 1'b1 || dr !== 1'b0 || er !== 1'b0 || lt !== 1'b0 || q !== exp_q) begin
          errors++; $display("FAIL up_step r%0d k%0d: early=%0b step=%0b dir=%0b err=%0b late=%0b q=%0h required 0 1 0 0 0 q=%0h",
                              r, k, e0, st, dr, er, lt, q, exp_q);
        end
      end
    end
    checks++; if (nsteps != 20 || q !== 4'h4) begin
      errors++; $display("FAIL up_total: steps=%0d q=%0h required 20 q=4", nsteps, q);
    end
  endtask

  task automatic test_down_en();
    logic e0, st, dr, er, lt;
    logic [1:0] seq [3] = '{2'b10, 2'b11, 2'b01};
    logic [3:0] expq [3] = '{4'h3, 4'h2, 4'h1};
    for (int k = 0; k < 3; k++) begin
      do_phase(seq[k], e0, st, dr, er, lt);
      checks++; if (st !== 1'b1 || dr !== 1'b1 || q !== expq[k]) begin
        errors++; $display("FAIL down_step k%0d: step=%0b dir=%0b q=%0h required 1 1 q=%0h", k, st, dr, q, expq[k]);
      end
    end
    en = 1'b0;
    do_phase(2'b00, e0, st, dr, er, lt);
    checks++; if (st !== 1'b0 || q !== 4'h1 || dir !== 1'b1) begin
      errors++; $display("FAIL en_hold1: step=%0b q=%0h dir=%0b required 0 1 1", st, q, dir);
    end
    do_phase(2'b10, e0, st, dr, er, lt);
    checks++; if (st !== 1'b0 || q !== 4'h1) begin
      errors++; $display("FAIL en_hold2: step=%0b q=%0h required 0 1", st, q);
    end
    en = 1'b1;
    do_phase(2'b11, e0, st, dr, er, lt);
    checks++; if (st !== 1'b1 || dr !== 1'b1 || q !== 4'h0) begin
      errors++; $display("FAIL en_resume: step=%0b dir=%0b q=%0h required 1 1 0", st, dr, q);
    end
  endtask

  task automatic test_illegal();
    logic e0, st, dr, er, lt;
    en = 1'b0;
    do_phase(2'b01, e0, st, dr, er, lt);
    do_phase(2'b00, e0, st, dr, er, lt);
    en = 1'b1;
    do_phase(2'b01, e0, st, dr, er, lt);
    en = 1'b0;
    do_phase(2'b00, e0, st, dr, er, lt);
    en = 1'b1;
    checks++; if (q !== 4'h1) begin errors++; $display("FAIL pre_illegal_q: got %0h required 1", q); end
    do_phase(2'b11, e0, st, dr, er, lt);
    checks++; if (e0 !== 1'b0 || er !== 1'b1 || st !== 1'b0 || lt !== 1'b0 || q !== 4'h1 || err_flag !== 1'b1) begin
      errors++; $display("FAIL illegal: early=%0b err=%0b step=%0b late=%0b q=%0h flag=%0b required 0 1 0 0 1 1", e0, er, st, lt, q, err_flag);
    end
    tick();
    tick();
    checks++; if (err_flag !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL flag_sticky: flag=%0b err=%0b required 1 0", err_flag, err);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (err_flag !== 1'b0 || q !== 4'h0) begin
      errors++; $display("FAIL clr_flag: flag=%0b q=%0h required 0 0", err_flag, q);
    end
  endtask

  task automatic test_clr_step();
    logic e0, st, dr, er, lt;
    logic [1:0] seq [8] = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
    for (int k = 0; k < 8; k++) do_phase(seq[k], e0, st, dr, er, lt);
    do_phase(2'b01, e0, st, dr, er, lt);
    checks++; if (q !== 4'h7 || dir !== 1'b1) begin
      errors++; $display("FAIL pre_clr_q: q=%0h dir=%0b required 7 1", q, dir);
    end
    {a, b} = 2'b11;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (q !== 4'h0 || step !== 1'b1 || dir !== 1'b0) begin
      errors++; $display("FAIL clr_with_step: q=%0h step=%0b dir=%0b required 0 1 0", q, step, dir);
    end
    tick();
    checks++; if (step !== 1'b0 || q !== 4'h0) begin
      errors++; $display("FAIL clr_step_after: step=%0b q=%0h required 0 0", step, q);
    end
  endtask

  task automatic test_reset_mid();
    logic e0, st, dr, er, lt;
    do_phase(2'b10, e0, st, dr, er, lt);
    checks++; if (q !== 4'h1 || ready !== 1'b1) begin
      errors++; $display("FAIL pre_reset_q: q=%0h ready=%0b required 1 1", q, ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (q !== 4'h0 || ready !== 1'b0 || dir !== 1'b0) begin
      errors++; $display("FAIL async_reset: q=%0h ready=%0b dir=%0b required 0 0 0", q, ready, dir);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reprime_edge1: got %0b required 0", ready); end
    tick();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reprime_edge2: got %0b required 1", ready); end
    tick();
    tick();
    checks++; if (step !== 1'b0 || err !== 1'b0 || q !== 4'h0) begin
      errors++; $display("FAIL reprime_quiet: step=%0b err=%0b q=%0h required 0 0 0", step, err, q);
    end
  endtask

`ifdef QDEC_INDEX_EN
  task automatic test_index();
    logic e0, st, dr, er, lt;
    logic [1:0] seq [3] = '{2'b00, 2'b01, 2'b11};
    for (int k = 0; k < 3; k++) do_phase(seq[k], e0, st, dr, er, lt);
    checks++; if (q !== 4'h3) begin errors++; $display("FAIL pre_index_q: got %0h required 3", q); end
    z = 1'b1;
    tick();
    tick();
    checks++; if (q !== 4'h3) begin errors++; $display("FAIL index_early: got %0h required 3", q); end
    tick();
    checks++; if (q !== 4'hA) begin errors++; $display("FAIL index_load: got %0h required a", q); end
    z = 1'b0;
    repeat (3) tick();
    z = 1'b1;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    z = 1'b0;
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL index_vs_clr: got %0h required 0", q); end
  endtask
`endif

  initial begin
    test_reset();
    test_up();
    test_down_en();
    test_illegal();
    test_clr_step();
    test_reset_mid();
`ifdef QDEC_INDEX_EN
    test_index();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
